// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sequencing a single-port memory between instruction fetch and data access.
// Optional statistics counters are enabled with `define MEM_ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int MEM_WIDTH   = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  RST,
  input  logic                  if_req,
  input  logic [MEM_WIDTH-1:0]  if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_valid,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [MEM_WIDTH-1:0]  dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_valid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]           conflict_cnt,
  output logic [15:0]           grant_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_q, grant_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [MEM_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  if_valid_q, if_valid_d;
  logic                  dm_valid_q, dm_valid_d;
  logic                  pick_dm;

  // Data wins when it is the only requester or when fetch won the previous grant.
  assign pick_dm = dm_req & (~if_req | (last_grant_q == GRANT_IF));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_valid_d   = 1'b0;
    dm_valid_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          grant_d    = pick_dm;
          mem_addr_d = pick_dm ? dm_addr : if_addr;
          if (pick_dm) mem_wdata_d = dm_wdata;
          mem_en_d   = 1'b1;
          mem_we_d   = pick_dm & dm_we;
          cnt_d      = CNT_INIT;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          // mem_rdata is valid on this final enable cycle
          if (grant_q == GRANT_IF) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            if (!mem_we_q) dm_rdata_d = mem_rdata;
            dm_valid_d = 1'b1;
          end
          state_d = RESP;
        end else begin
          mem_en_d = 1'b1;
          mem_we_d = mem_we_q;
          cnt_d    = cnt_q - 4'd1;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= GRANT_IF;
      grant_q      <= GRANT_IF;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_valid_q   <= 1'b0;
      dm_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_valid_q   <= if_valid_d;
      dm_valid_q   <= dm_valid_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign stall     = (if_req & ~if_valid_q) | (dm_req & ~dm_valid_q);

`ifdef MEM_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic [15:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    grant_cnt_d    = grant_cnt_q;
    if ((state_q == IDLE) && if_req && dm_req && (conflict_cnt_q != 16'hFFFF))
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    // RESP is exactly the cycle in which a valid pulse is presented
    if (state_q == RESP)
      grant_cnt_d = grant_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      conflict_cnt_q <= 16'd0;
      grant_cnt_q    <= 16'd0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      grant_cnt_q    <= grant_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
  assign grant_cnt    = grant_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected read data, a negedge monitor pops on each valid.
module tb_mem_port_arbiter;

  logic        clk_in = 1'b0;
  logic        RST;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic [15:0] if_rdata, dm_rdata;
  logic        if_valid, dm_valid;
  logic        mem_en, mem_we, stall;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] conflict_cnt, grant_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_if[$];
  logic [15:0] exp_dm[$];
  logic [15:0] tbmem [0:255];

  always #5 clk_in = ~clk_in;

  mem_port_arbiter #(.MEM_WIDTH(16), .DATA_WIDTH(16), .MEM_LATENCY(2)) dut (
    .clk_in    (clk_in),
    .RST       (RST),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_valid  (dm_valid),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall     (stall)
`ifdef MEM_ARB_STATS_EN
    ,
    .conflict_cnt (conflict_cnt),
    .grant_cnt    (grant_cnt)
`endif
  );

  // Small memory model: combinational read, write on every enabled write cycle.
  assign mem_rdata = tbmem[mem_addr[7:0]];
  always @(posedge clk_in) if (mem_en && mem_we) tbmem[mem_addr[7:0]] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (if_valid) begin
      if (exp_if.size() == 0) chk("if unexpected valid", 1, 0);
      else chk("if_rdata", if_rdata, exp_if.pop_front());
    end
    if (dm_valid) begin
      if (exp_dm.size() == 0) chk("dm unexpected valid", 1, 0);
      else chk("dm_rdata", dm_rdata, exp_dm.pop_front());
    end
  end

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge clk_in);
    RST = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the idle cycle after RESP.
  task automatic do_single(input string nm, input bit is_dm, input bit we,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rdexp);
    int k;
    if (is_dm) begin
      exp_dm.push_back(rdexp);
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      exp_if.push_back(rdexp);
      if_req = 1'b1; if_addr = addr;
    end
    @(negedge clk_in);
    chk({nm, " mem_en"}, mem_en, 1);
    chk({nm, " mem_we"}, mem_we, we);
    chk({nm, " mem_addr"}, mem_addr, addr);
    if (we) chk({nm, " mem_wdata"}, mem_wdata, wdata);
    k = 1;
    while (!(is_dm ? dm_valid : if_valid) && k < 20) begin
      @(negedge clk_in);
      k++;
    end
    chk({nm, " latency"}, k, 3);
    chk({nm, " stall at valid"}, stall, 0);
    if (is_dm) dm_req = 1'b0; else if_req = 1'b0;
    @(negedge clk_in);
    chk({nm, " valid is one pulse"}, {if_valid, dm_valid}, 0);
  endtask

  task automatic serve_both(input logic [15:0] ia, input logic [15:0] da,
                            input logic [15:0] iexp, input logic [15:0] dexp);
    bit gi, gd;
    int k;
    gi = 0; gd = 0; k = 0;
    exp_if.push_back(iexp);
    exp_dm.push_back(dexp);
    if_req = 1'b1; if_addr = ia;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = da;
    while (!(gi && gd) && k < 30) begin
      @(negedge clk_in);
      if (dm_valid) begin gd = 1; dm_req = 1'b0; end
      if (if_valid) begin gi = 1; if_req = 1'b0; end
      k++;
    end
    chk("pair both served", {gi, gd}, 2'b11);
    @(negedge clk_in);
  endtask

  initial begin
    RST = 1'b1; if_req = 0; dm_req = 0; dm_we = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0;
    for (int i = 0; i < 256; i++) tbmem[i] = 16'h0000;
    tbmem[8'h10] = 16'hABCD;
    tbmem[8'h20] = 16'h5555;
    tbmem[8'h30] = 16'h7777;
    @(negedge clk_in);
    do_reset();

    // Reset state
    chk("reset mem_en/we", {mem_en, mem_we}, 0);
    chk("reset valids", {if_valid, dm_valid}, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    chk("reset rdata", {if_rdata, dm_rdata}, 0);
    chk("reset stall", stall, 0);
`ifdef MEM_ARB_STATS_EN
    chk("reset counters", {conflict_cnt, grant_cnt}, 0);
`endif

    // Single fetch, with if_addr changed mid-access to show it was latched
    exp_if.push_back(16'hABCD);
    if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk_in);
    chk("fetch en c1", mem_en, 1);
    chk("fetch addr c1", mem_addr, 16'h0010);
    chk("fetch stall c1", stall, 1);
    if_addr = 16'h0099;
    @(negedge clk_in);
    chk("fetch en c2", mem_en, 1);
    chk("fetch addr latched", mem_addr, 16'h0010);
    @(negedge clk_in);
    chk("fetch en c3", mem_en, 0);
    chk("fetch valid c3", if_valid, 1);
    chk("fetch stall c3", stall, 0);
    if_req = 1'b0;
    @(negedge clk_in);
    chk("fetch valid c4", if_valid, 0);

    // Store, load back, second store leaves dm_rdata untouched
    do_single("store1", 1, 1, 16'h0200, 16'h1234, 16'h0000);
    chk("store mem_en off", mem_en, 0);
    do_single("load1", 1, 0, 16'h0200, 16'h0000, 16'h1234);
    do_single("store2", 1, 1, 16'h0201, 16'hBEEF, 16'h1234);
    chk("fetch rdata held", if_rdata, 16'hABCD);

    // Contention from reset: data first, fetch 4 cycles later
    do_reset();
    exp_dm.push_back(16'h7777);
    exp_if.push_back(16'h5555);
    if_req = 1'b1; if_addr = 16'h0020;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0030;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk_in);
      if (c == 1) chk("cont first grant addr", mem_addr, 16'h0030);
      if (c == 3) begin
        chk("cont dm_valid c3", {dm_valid, if_valid}, 2'b10);
        dm_req = 1'b0;
      end
      if (c == 5) chk("cont second grant addr", {mem_en, mem_addr}, {1'b1, 16'h0020});
      if (c < 7) chk($sformatf("cont stall c%0d", c), stall, 1);
      if (c == 7) begin
        chk("cont if_valid c7", {if_valid, dm_valid}, 2'b10);
        chk("cont stall at if_valid", stall, 0);
        if_req = 1'b0;
      end
    end
    @(negedge clk_in);

    // Reset during the second access cycle abandons the fetch
    if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk_in);
    chk("abort en c1", mem_en, 1);
    @(negedge clk_in);
    RST = 1'b1;
    @(negedge clk_in);
    chk("abort mem_en cleared", mem_en, 0);
    RST = 1'b0; if_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      chk("abort no valid", {if_valid, dm_valid}, 0);
    end
    chk("abort if_rdata cleared", if_rdata, 0);
    do_single("fetch after abort", 0, 0, 16'h0020, 16'h0000, 16'h5555);

`ifdef MEM_ARB_STATS_EN
    do_reset();
    serve_both(16'h0010, 16'h0030, 16'hABCD, 16'h7777);
    serve_both(16'h0020, 16'h0200, 16'h5555, 16'h1234);
    serve_both(16'h0010, 16'h0201, 16'hABCD, 16'hBEEF);
    chk("stats grant_cnt", grant_cnt, 6);
    chk("stats conflict_cnt", conflict_cnt, 3);
`else
    serve_both(16'h0010, 16'h0030, 16'hABCD, 16'h7777);
`endif

    repeat (3) @(negedge clk_in);
    chk("scoreboard drained", exp_if.size() + exp_dm.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
